// File: rtl/ccu_mul_seq_pkg.sv
// Shared types and defaults for the ccu multiply sequencer.
// States, default timing constants and a counter width helper.
package ccu_mul_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } seq_state_e;

    localparam int DEF_MINOR_LEN    = 18;
    localparam int DEF_SHORT_DIGITS = 17;
    localparam int DEF_LONG_DIGITS  = 35;
    localparam int DEF_ONES_LEN     = 1;

    // Wide enough for a long-mode digit period.
    function automatic int pos_width(input int minor_len);
        return $clog2(2 * minor_len);
    endfunction

endpackage

// File: rtl/ccu_pos_counter.sv
// Modulo-P position counter locked to ev_d0, with off-grid detect.
// Ports: clk, rst_n, en (count, else hold 0), chk (grid checking),
//   long_sel (P = 2*MINOR_LEN), ev_d0, pos_nxt (next-clock position),
//   off_grid (ev_d0 seen at a position that is not a period start).
module ccu_pos_counter
    import ccu_mul_seq_pkg::*;
#(
    parameter int MINOR_LEN = DEF_MINOR_LEN,
    parameter int PW        = pos_width(DEF_MINOR_LEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          chk,
    input  logic          long_sel,
    input  logic          ev_d0,
    output logic [PW-1:0] pos_nxt,
    output logic          off_grid
);

    localparam logic [PW-1:0] MID    = PW'(MINOR_LEN);
    localparam logic [PW-1:0] LAST_S = PW'(MINOR_LEN - 1);
    localparam logic [PW-1:0] LAST_L = PW'(2 * MINOR_LEN - 1);

    logic [PW-1:0] pos_q;
    logic [PW-1:0] pos_cur;
    logic [PW-1:0] last;
    logic          on_grid;

    // In long mode the mid-period ev_d0 is expected and must not
    // disturb the count.
    assign on_grid  = (pos_q == '0) || (long_sel && pos_q == MID);
    assign off_grid = chk && ev_d0 && !on_grid;

    // Before checking starts every ev_d0 defines the grid.
    assign pos_cur = (ev_d0 && (!chk || !on_grid)) ? '0 : pos_q;
    assign last    = long_sel ? LAST_L : LAST_S;
    assign pos_nxt = (pos_cur == last) ? '0 : pos_cur + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= '0;
        end else begin
            pos_q <= en ? pos_nxt : '0;
        end
    end

endmodule

// File: rtl/ccu_mul_seq.sv
// Multiplication sequencer: digit test, multiplicand gating, clear.
// Ports: clk, rst_n, start, long_mode, abort, ev_d0, dx_m, da_n in;
//   dx, g3_pos, sub_dig, ones, dy, busy, done, sync_err, digit_idx out.
module ccu_mul_seq
    import ccu_mul_seq_pkg::*;
#(
    parameter int MINOR_LEN    = DEF_MINOR_LEN,
    parameter int SHORT_DIGITS = DEF_SHORT_DIGITS,
    parameter int LONG_DIGITS  = DEF_LONG_DIGITS,
    parameter int ONES_LEN     = DEF_ONES_LEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic long_mode,
    input  logic abort,
    input  logic ev_d0,
    input  logic dx_m,
    input  logic da_n,
    output logic dx,
    output logic g3_pos,
    output logic sub_dig,
    output logic ones,
    output logic dy,
    output logic busy,
    output logic done,
    output logic sync_err,
    output logic [$clog2(LONG_DIGITS+1)-1:0] digit_idx
);

    localparam int IW = $clog2(LONG_DIGITS + 1);
    localparam int PW = pos_width(MINOR_LEN);

    localparam logic [PW-1:0] POS_DX = PW'(1);
    localparam logic [PW-1:0] OL_S   = PW'(MINOR_LEN - ONES_LEN);
    localparam logic [PW-1:0] OL_L   = PW'(2 * MINOR_LEN - ONES_LEN);

    seq_state_e    state;
    seq_state_e    state_nxt;
    logic          start_ok;
    logic          long_q;
    logic          bit_q;
    logic          neg_q;
    logic [IW-1:0] n_last_q;
    logic [PW-1:0] pos_nxt;
    logic          off_grid;
    logic          run_nxt;
    logic          cur_bit;
    logic          cur_neg;
    logic          in_tail;
    logic          g3_nxt;
    logic          dy_nxt;
    logic          last_dig;

    ccu_pos_counter #(
        .MINOR_LEN (MINOR_LEN),
        .PW        (PW)
    ) u_pos (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (state_nxt != ST_IDLE),
        .chk      (state == ST_RUN),
        .long_sel (long_q),
        .ev_d0    (ev_d0),
        .pos_nxt  (pos_nxt),
        .off_grid (off_grid)
    );

    assign start_ok = !abort && state == ST_IDLE && start;

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: if (start) state_nxt = ST_SYNC;
                ST_SYNC: if (ev_d0) state_nxt = ST_RUN;
                ST_RUN:  if (done)  state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // dx_m/da_n are only meaningful in the dx clock; otherwise
    // the values latched then are used.
    assign cur_bit  = dx ? dx_m : bit_q;
    assign cur_neg  = dx ? da_n : neg_q;
    assign run_nxt  = state_nxt == ST_RUN;
    assign in_tail  = (pos_nxt == '0) ||
                      (pos_nxt > (long_q ? OL_L : OL_S));
    // The window spans every position except the test slot.
    assign g3_nxt   = run_nxt && cur_bit && pos_nxt != POS_DX;
    assign dy_nxt   = run_nxt && pos_nxt == '0;
    assign last_dig = digit_idx == n_last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            dx        <= 1'b0;
            g3_pos    <= 1'b0;
            sub_dig   <= 1'b0;
            ones      <= 1'b0;
            dy        <= 1'b0;
            done      <= 1'b0;
            sync_err  <= 1'b0;
            digit_idx <= '0;
            long_q    <= 1'b0;
            n_last_q  <= '0;
            bit_q     <= 1'b0;
            neg_q     <= 1'b0;
        end else begin
            state   <= state_nxt;
            busy    <= state_nxt != ST_IDLE;
            dx      <= run_nxt && pos_nxt == POS_DX;
            g3_pos  <= g3_nxt;
            sub_dig <= g3_nxt && last_dig;
            ones    <= g3_nxt && cur_neg && in_tail;
            dy      <= dy_nxt;
            done    <= dy_nxt && last_dig;

            if (dx) begin
                bit_q <= dx_m;
                neg_q <= da_n;
            end

            if (start_ok) begin
                long_q   <= long_mode;
                n_last_q <= long_mode ? IW'(LONG_DIGITS - 1)
                                      : IW'(SHORT_DIGITS - 1);
            end

            if (start_ok) begin
                sync_err <= 1'b0;
            end else if (!abort && state == ST_RUN && off_grid) begin
                sync_err <= 1'b1;
            end

            if (state_nxt == ST_IDLE) begin
                digit_idx <= '0;
            end else if (dy) begin
                digit_idx <= digit_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ccu_mul_seq.sv
// Scoreboard bench for ccu_mul_seq.
// Stimulus queues expected dx/dy/done events; a monitor checks them.
module tb_ccu_mul_seq;
    import ccu_mul_seq_pkg::*;

    localparam int ML   = 18;
    localparam int NS   = 17;
    localparam int NL   = 35;
    localparam int PS   = ML;
    localparam int PL   = 2 * ML;
    localparam int ONES = 1;

    localparam int K_DX   = 1;
    localparam int K_DY   = 2;
    localparam int K_DONE = 3;

    typedef struct {
        int kind;
        int t;
        int idx;
        int g3;
        int on;
        int sb;
    } ev_t;

    logic clk;
    logic rst_n;
    logic start;
    logic long_mode;
    logic abort;
    logic ev_d0;
    logic dx_m;
    logic da_n;
    logic dx;
    logic g3_pos;
    logic sub_dig;
    logic ones;
    logic dy;
    logic busy;
    logic done;
    logic sync_err;
    logic [5:0] digit_idx;
    logic [6:0] outs;

    logic [34:0] mpl;
    logic        neg_cfg;
    logic        noise;

    ev_t q[$];
    int  cyc;
    int  ph;
    int  checks;
    int  errors;
    int  g3c;
    int  onc;
    int  sbc;

    ccu_mul_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .long_mode (long_mode),
        .abort     (abort),
        .ev_d0     (ev_d0),
        .dx_m      (dx_m),
        .da_n      (da_n),
        .dx        (dx),
        .g3_pos    (g3_pos),
        .sub_dig   (sub_dig),
        .ones      (ones),
        .dy        (dy),
        .busy      (busy),
        .done      (done),
        .sync_err  (sync_err),
        .digit_idx (digit_idx)
    );

    assign outs = {dx, g3_pos, sub_dig, ones, dy, busy, done};

    // Operand store: answers only while dx is high, noise otherwise.
    assign dx_m = dx ? mpl[digit_idx] : noise;
    assign da_n = dx ? neg_cfg : noise;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial noise = 1'b0;
    always @(posedge clk) noise <= ~noise;

    function automatic void chk(input string nm, input int act,
                                input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d act=%0d exp=%0d",
                     nm, cyc, act, exp);
        end
    endfunction

    function automatic void push_ev(input int k, input int t,
                                    input int idx, input int g3,
                                    input int on, input int sb);
        ev_t e;
        e.kind = k;
        e.t    = t;
        e.idx  = idx;
        e.g3   = g3;
        e.on   = on;
        e.sb   = sb;
        q.push_back(e);
    endfunction

    function automatic void push_run(input int base, input int k0,
                                     input int k1, input int p,
                                     input logic [34:0] m,
                                     input bit ng, input int n);
        for (int k = k0; k <= k1; k++) begin
            int b;
            int tdy;
            b   = k - k0;
            tdy = base + (b + 1) * p;
            push_ev(K_DX, base + b * p + 1, k, 0, 0, 0);
            push_ev(K_DY, tdy, k,
                    m[k] ? p - 1 : 0,
                    (m[k] && ng) ? ONES : 0,
                    (m[k] && k == n - 1) ? p - 1 : 0);
            if (k == n - 1) push_ev(K_DONE, tdy, k, 0, 0, 0);
        end
    endfunction

    task automatic mon_pop(input int kind);
        ev_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event cyc=%0d act=%0d exp=none",
                     cyc, kind);
            return;
        end
        e = q.pop_front();
        chk("ev_kind", kind, e.kind);
        chk("ev_time", cyc, e.t);
        chk("ev_idx", int'(digit_idx), e.idx);
        if (kind == K_DY) begin
            chk("g3_clocks", g3c, e.g3);
            chk("ones_clocks", onc, e.on);
            chk("sub_clocks", sbc, e.sb);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (dx) begin
                g3c = 0;
                onc = 0;
                sbc = 0;
            end
            g3c += int'(g3_pos);
            onc += int'(ones);
            sbc += int'(sub_dig);
            if (ones) chk("ones_at_dy", int'(dy), 1);
            if (dx)   mon_pop(K_DX);
            if (dy)   mon_pop(K_DY);
            if (done) mon_pop(K_DONE);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        ev_d0 = 1'b0;
    endtask

    task automatic run_clk(input int n);
        for (int i = 0; i < n; i++) begin
            ev_d0 = (ph == 0);
            ph    = (ph + 1) % ML;
            tick();
        end
    endtask

    task automatic begin_op(input bit lng, output int t0);
        start     = 1'b1;
        long_mode = lng;
        tick();
        long_mode = !lng;
        tick();
        t0 = cyc;
        ph = 0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            run_clk(1);
            n++;
        end
        chk("drain_pending", q.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d act=running exp=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int t1;
        checks    = 0;
        errors    = 0;
        g3c       = 0;
        onc       = 0;
        sbc       = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        ev_d0     = 1'b0;
        long_mode = 1'b0;
        mpl       = '0;
        neg_cfg   = 1'b0;
        ph        = 1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", int'(outs), 0);
        chk("rst_idx", int'(digit_idx), 0);
        chk("rst_serr", int'(sync_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Short multiply, every digit 1, positive multiplicand.
        mpl     = '1;
        neg_cfg = 1'b0;
        begin_op(1'b0, t0);
        chk("a_busy", int'(busy), 1);
        push_run(t0, 0, NS - 1, PS, mpl, 1'b0, NS);
        run_clk(NS * PS);
        wait_drain(40);
        run_clk(2);
        chk("a_idle", int'(outs), 0);
        chk("a_serr", int'(sync_err), 0);

        // Sparse multiplier, negative multiplicand.
        mpl     = 35'h10001;
        neg_cfg = 1'b1;
        begin_op(1'b0, t0);
        push_run(t0, 0, NS - 1, PS, mpl, 1'b1, NS);
        run_clk(NS * PS);
        wait_drain(40);

        // Long multiply; mid-period ev_d0 is on grid.
        mpl     = '1;
        neg_cfg = 1'b0;
        begin_op(1'b1, t0);
        push_run(t0, 0, NL - 1, PL, mpl, 1'b0, NL);
        run_clk(NL * PL);
        wait_drain(60);
        chk("c_serr", int'(sync_err), 0);

        // Off-grid ev_d0 at position 7 of digit 3.
        begin_op(1'b0, t0);
        push_run(t0, 0, 2, PS, mpl, 1'b0, NS);
        push_ev(K_DX, t0 + 3 * PS + 1, 3, 0, 0, 0);
        run_clk(3 * PS + 7);
        t1 = cyc;
        push_run(t1, 3, NS - 1, PS, mpl, 1'b0, NS);
        ev_d0 = 1'b1;
        ph    = 1;
        tick();
        run_clk(1);
        chk("d_serr_set", int'(sync_err), 1);
        run_clk(14 * PS - 1);
        wait_drain(40);
        chk("d_serr_sticky", int'(sync_err), 1);

        // Abort inside the window of digit 5.
        begin_op(1'b0, t0);
        chk("e_serr_clr", int'(sync_err), 0);
        push_run(t0, 0, 4, PS, mpl, 1'b0, NS);
        push_ev(K_DX, t0 + 5 * PS + 1, 5, 0, 0, 0);
        run_clk(5 * PS + 10);
        chk("e_g3_live", int'(g3_pos), 1);
        abort = 1'b1;
        run_clk(1);
        chk("e_abort_outs", int'(outs), 0);
        run_clk(2 * PS);
        chk("e_no_done", q.size(), 0);

        // Start while busy must not disturb the run.
        begin_op(1'b0, t0);
        push_run(t0, 0, NS - 1, PS, mpl, 1'b0, NS);
        run_clk(2 * PS + 5);
        start     = 1'b1;
        long_mode = 1'b1;
        run_clk(1);
        chk("f_busy", int'(busy), 1);
        run_clk(NS * PS - 2 * PS - 6);
        wait_drain(40);

        // Asynchronous reset during digit 8.
        begin_op(1'b0, t0);
        push_run(t0, 0, 7, PS, mpl, 1'b0, NS);
        push_ev(K_DX, t0 + 8 * PS + 1, 8, 0, 0, 0);
        run_clk(8 * PS + 5);
        chk("g_g3_live", int'(g3_pos), 1);
        rst_n = 1'b0;
        #1;
        chk("g_rst_outs", int'(outs), 0);
        chk("g_rst_idx", int'(digit_idx), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_clk(2 * PS);
        chk("g_pending", q.size(), 0);
        chk("g_quiet", int'(outs), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
